// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the I/Q accumulator path: FSM encoding, fs/4 LO
// phase meaning, sample conversion and the accumulator width rule.
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // fs/4 LO: cos = 1,0,-1,0 and sin = 0,1,0,-1, so each phase touches one accumulator
    localparam logic [1:0] LO_I_POS = 2'd0;
    localparam logic [1:0] LO_Q_NEG = 2'd1;
    localparam logic [1:0] LO_I_NEG = 2'd2;
    localparam logic [1:0] LO_Q_POS = 2'd3;

    // Offset-binary to two's complement: raw holds a zero-extended w-bit sample.
    function automatic logic signed [31:0] ob_to_signed(input logic [31:0] raw, input int w);
        return $signed(raw) - (32'sd1 <<< (w - 1));
    endfunction

    function automatic bit acc_width_ok(input int acc_w, input int sig_w, input int max_avg);
        return acc_w >= sig_w + max_avg + 1;
    endfunction

endpackage

// File: rtl/iq_mix_acc.sv
// One channel: offset-binary conversion, fs/4 LO phase mux and I/Q accumulators.
// nxt_* exposes the post-update sums so the top can capture the final sample's contribution.
module iq_mix_acc #(
    parameter int sig_width = 12,
    parameter int acc_width = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic [1:0]                  phase,
    input  logic [sig_width-1:0]        sample,
    output logic signed [acc_width-1:0] acc_i,
    output logic signed [acc_width-1:0] acc_q,
    output logic signed [acc_width-1:0] nxt_i,
    output logic signed [acc_width-1:0] nxt_q
);
    import dsp_pkg::*;

    logic signed [31:0]          x32;
    logic signed [acc_width-1:0] x;

    assign x32 = ob_to_signed(32'(sample), sig_width);
    assign x   = acc_width'(x32);

    always_comb begin
        nxt_i = acc_i;
        nxt_q = acc_q;
        case (phase)
            LO_I_POS: nxt_i = acc_i + x;
            LO_Q_NEG: nxt_q = acc_q - x;
            LO_I_NEG: nxt_i = acc_i - x;
            LO_Q_POS: nxt_q = acc_q + x;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (en) begin
            acc_i <= nxt_i;
            acc_q <= nxt_q;
        end
    end

endmodule

// File: rtl/iq_accum.sv
// fs/4 I/Q demodulator and averager for the filtered A/B pair; delivers four
// signed sums per measurement to the sweep controller over a valid/ack handshake.
module iq_accum #(
    parameter int sig_width    = 12,
    parameter int acc_width    = 32,
    parameter int max_avg_log2 = 16,
    parameter int discard_w    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [4:0]                  avg_log2,
    input  logic [discard_w-1:0]        discard_n,
    input  logic                        filt_done,
    input  logic [sig_width-1:0]        filt_a,
    input  logic [sig_width-1:0]        filt_b,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ack,
    output logic signed [acc_width-1:0] i_a,
    output logic signed [acc_width-1:0] q_a,
    output logic signed [acc_width-1:0] i_b,
    output logic signed [acc_width-1:0] q_b
);
    import dsp_pkg::*;

    localparam int CNT_W = max_avg_log2 + 1;

    if (!acc_width_ok(acc_width, sig_width, max_avg_log2)) begin : g_width_chk
        $error("iq_accum: acc_width too narrow for sig_width + max_avg_log2");
    end

    state_t                      state_q, state_d;
    logic                        go, acc_en, last;
    logic [4:0]                  avg_len_d, avg_len_q;
    logic [discard_w-1:0]        disc_cnt;
    logic [CNT_W-1:0]            smp_cnt, last_idx;
    logic [1:0]                  phase_q;
    logic signed [acc_width-1:0] acc_ia, acc_qa, acc_ib, acc_qb;
    logic signed [acc_width-1:0] nxt_ia, nxt_qa, nxt_ib, nxt_qb;

    // Clamp so the average always spans whole LO periods and never exceeds the width rule
    always_comb begin
        if (avg_log2 < 5'd2)
            avg_len_d = 5'd2;
        else if (avg_log2 > 5'(max_avg_log2))
            avg_len_d = 5'(max_avg_log2);
        else
            avg_len_d = avg_log2;
    end

    assign last_idx = (CNT_W'(1) << avg_len_q) - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        acc_en  = 1'b0;
        last    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    go      = 1'b1;
                    state_d = (discard_n == '0) ? ST_ACCUM : ST_DISCARD;
                end
                ST_DISCARD: if (filt_done && disc_cnt == discard_w'(1)) state_d = ST_ACCUM;
                ST_ACCUM: if (filt_done) begin
                    acc_en = 1'b1;
                    if (smp_cnt == last_idx) begin
                        last    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        go      = 1'b1;
                        state_d = (discard_n == '0) ? ST_ACCUM : ST_DISCARD;
                    end else if (res_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            avg_len_q <= '0;
            disc_cnt  <= '0;
            smp_cnt   <= '0;
            phase_q   <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                avg_len_q <= avg_len_d;
                disc_cnt  <= discard_n;
                smp_cnt   <= '0;
                phase_q   <= '0;
            end else begin
                if (state_q == ST_DISCARD && filt_done) disc_cnt <= disc_cnt - discard_w'(1);
                if (acc_en) begin
                    smp_cnt <= smp_cnt + CNT_W'(1);
                    phase_q <= phase_q + 2'd1;
                end
            end
        end
    end

    iq_mix_acc #(.sig_width(sig_width), .acc_width(acc_width)) u_mix_a (
        .clk(clk), .rst(rst), .clr(go), .en(acc_en), .phase(phase_q), .sample(filt_a),
        .acc_i(acc_ia), .acc_q(acc_qa), .nxt_i(nxt_ia), .nxt_q(nxt_qa)
    );

    iq_mix_acc #(.sig_width(sig_width), .acc_width(acc_width)) u_mix_b (
        .clk(clk), .rst(rst), .clr(go), .en(acc_en), .phase(phase_q), .sample(filt_b),
        .acc_i(acc_ib), .acc_q(acc_qb), .nxt_i(nxt_ib), .nxt_q(nxt_qb)
    );

    // Results capture the final sample's contribution on the same edge DONE is entered
    always_ff @(posedge clk) begin
        if (rst) begin
            i_a <= '0;
            q_a <= '0;
            i_b <= '0;
            q_b <= '0;
        end else if (last) begin
            i_a <= nxt_ia;
            q_a <= nxt_qa;
            i_b <= nxt_ib;
            q_b <= nxt_qb;
        end
    end

    assign busy      = (state_q == ST_DISCARD) || (state_q == ST_ACCUM);
    assign res_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_iq_accum.sv
// Scoreboard bench for iq_accum: stimulus pushes hand-computed results, a
// negedge monitor pops and compares each time res_valid rises.
module tb_iq_accum;

    typedef struct {
        int ia;
        int qa;
        int ib;
        int qb;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [4:0]        avg_log2 = '0;
    logic [7:0]        discard_n = '0;
    logic              filt_done = 1'b0;
    logic [11:0]       filt_a = '0;
    logic [11:0]       filt_b = '0;
    logic              busy;
    logic              res_valid;
    logic              res_ack = 1'b0;
    logic signed [31:0] i_a, q_a, i_b, q_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic rv_prev = 1'b0;

    logic [11:0] pat_c [4] = '{12'd2048, 12'd2048, 12'd2048, 12'd2048};
    logic [11:0] pat_a [4] = '{12'd3048, 12'd2048, 12'd1048, 12'd2048};
    logic [11:0] pat_b [4] = '{12'd2048, 12'd3048, 12'd2048, 12'd1048};
    logic [11:0] fs_a  [4] = '{12'd4095, 12'd2048, 12'd0,    12'd2048};
    logic [11:0] fs_b  [4] = '{12'd2048, 12'd4095, 12'd2048, 12'd0};

    iq_accum dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .avg_log2(avg_log2), .discard_n(discard_n),
        .filt_done(filt_done), .filt_a(filt_a), .filt_b(filt_b),
        .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
        .i_a(i_a), .q_a(q_a), .i_b(i_b), .q_b(q_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus, applied just after a negedge; pulses drop afterwards.
    task automatic cyc(input bit st, input bit fd, input bit ack, input bit ab,
                       input logic [11:0] a, input logic [11:0] b);
        start = st; filt_done = fd; res_ack = ack; abort = ab; filt_a = a; filt_b = b;
        @(negedge clk);
        start = 1'b0; filt_done = 1'b0; res_ack = 1'b0; abort = 1'b0;
    endtask

    task automatic meas(input logic [4:0] avg, input logic [7:0] disc, input int n,
                        input logic [11:0] pa [4], input logic [11:0] pb [4],
                        input int gap, input bit st_fd, input exp_t e);
        sbq.push_back(e);
        avg_log2  = avg;
        discard_n = disc;
        cyc(1'b1, st_fd, 1'b0, 1'b0, 12'd4095, 12'd4095);
        chk("busy_after_start", busy, 1);
        chk("rv_after_start", res_valid, 0);
        for (int d = 0; d < disc; d++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'd4095, 12'd0);
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, pa[k % 4], pb[k % 4]);
            if (k < n - 1) repeat (gap) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
        end
        chk("rv_latency", res_valid, 1);
        chk("busy_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && !rv_prev) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: res_valid rose, expected no result");
            end else begin
                mon_e = sbq.pop_front();
                chk("i_a", i_a, mon_e.ia);
                chk("q_a", q_a, mon_e.qa);
                chk("i_b", i_b, mon_e.ib);
                chk("q_b", q_b, mon_e.qb);
            end
        end
        rv_prev = res_valid;
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_i_a", i_a, 0);
        chk("rst_q_b", q_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // filt_done in IDLE is ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'd4095, 12'd4095);
        chk("idle_strobe_busy", busy, 0);

        meas(5'd4, 8'd0, 16, pat_c, pat_c, 0, 1'b0, '{0, 0, 0, 0});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0);
        chk("ack_clears_rv", res_valid, 0);

        // start+filt_done same cycle: that sample must not count; gapped strobes
        meas(5'd2, 8'd0, 4, pat_a, pat_c, 1, 1'b1, '{2000, 0, 0, 0});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0);
        chk("hold_after_ack_i_a", i_a, 2000);

        meas(5'd3, 8'd0, 8, pat_a, pat_b, 0, 1'b0, '{4000, 0, 0, -4000});

        // restart straight from DONE; discard 3, avg_log2=0 clamps to 4 samples
        meas(5'd0, 8'd3, 4, pat_a, pat_b, 0, 1'b0, '{2000, 0, 0, -2000});
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0);
        chk("ack_abort_rv", res_valid, 0);
        chk("ack_abort_busy", busy, 0);

        // abort after 5 of 16 strobes
        avg_log2 = 5'd4;
        discard_n = 8'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, pat_a[k % 4], pat_b[k % 4]);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0);
        chk("abort_busy", busy, 0);
        chk("abort_rv", res_valid, 0);
        chk("abort_keep_i_a", i_a, 2000);
        chk("abort_keep_q_b", q_b, -2000);
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, pat_a[k % 4], pat_b[k % 4]);
        chk("abort_stays_idle", busy, 0);

        // full scale, longest average: no wrap
        meas(5'd16, 8'd0, 65536, fs_a, fs_b, 0, 1'b0, '{67092480, 0, 0, -67092480});
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0);

        // reset mid-measurement
        avg_log2 = 5'd4;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, pat_a[k % 4], pat_b[k % 4]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_rv", res_valid, 0);
        chk("midrst_i_a", i_a, 0);
        chk("midrst_q_b", q_b, 0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
